// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared
// single-bit-shift ALU for ADD, SLL and SRL steps, one step per cycle.

package definitions;
    parameter int D_WIDTH = 8;

    localparam logic [2:0] OP_R_TYPE = 3'b000;
    localparam logic [2:0] OP_SHIFT  = 3'b101;

    localparam logic [1:0] FUNCT_ADD = 2'b00;
    localparam logic [1:0] FUNCT_SLL = 2'b10;
    localparam logic [1:0] FUNCT_SRL = 2'b11;
endpackage

module alu_mul_sequencer #(
    parameter int D_WIDTH = definitions::D_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start_valid,
    output logic               o_start_ready,
    input  logic [D_WIDTH-1:0] i_op_a,
    input  logic [D_WIDTH-1:0] i_op_b,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [D_WIDTH-1:0] o_product,
    output logic               o_overflow,
    output logic               o_alu_busy,
    output logic [D_WIDTH-1:0] o_alu_src_a,
    output logic [D_WIDTH-1:0] o_alu_src_b,
    output logic [2:0]         o_alu_opcode,
    output logic [1:0]         o_alu_funct,
    input  logic [D_WIDTH-1:0] i_alu_result,
    input  logic               i_alu_carry_out,
    output logic [2:0]         o_dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready are
    // both high; ready and valid come from state only, never from the peer.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [D_WIDTH-1:0] r_m;
    logic [D_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_p;
    logic               r_ovf;
    logic               w_accept;
    logic               w_q_rest_nz;

    // A bit shifted out of M only corrupts the product if a later multiplier bit uses it.
    assign w_q_rest_nz = (r_q >> 1) != '0;

    assign o_product   = r_p;
    assign o_overflow  = r_ovf;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        o_start_ready = 1'b0;
        o_resp_valid  = 1'b0;
        o_alu_busy    = 1'b0;
        o_alu_src_a   = '0;
        o_alu_src_b   = '0;
        o_alu_opcode  = definitions::OP_R_TYPE;
        o_alu_funct   = definitions::FUNCT_ADD;
        case (r_state)
            S_IDLE: begin
                o_start_ready = 1'b1;
                if (i_start_valid) begin
                    w_accept = 1'b1;
                    if (i_op_b == '0)   w_next_state = S_DONE;
                    else if (i_op_b[0]) w_next_state = S_ADD;
                    else                w_next_state = S_SHL;
                end
            end
            S_ADD: begin
                o_alu_busy   = 1'b1;
                o_alu_src_a  = r_p;
                o_alu_src_b  = r_m;
                w_next_state = S_SHL;
            end
            S_SHL: begin
                o_alu_busy   = 1'b1;
                o_alu_opcode = definitions::OP_SHIFT;
                o_alu_funct  = definitions::FUNCT_SLL;
                o_alu_src_a  = r_m;
                w_next_state = S_SHR;
            end
            S_SHR: begin
                o_alu_busy   = 1'b1;
                o_alu_opcode = definitions::OP_SHIFT;
                o_alu_funct  = definitions::FUNCT_SRL;
                o_alu_src_a  = r_q;
                // Decide on the shifted multiplier now to skip a dead cycle.
                if (i_alu_result == '0)   w_next_state = S_DONE;
                else if (i_alu_result[0]) w_next_state = S_ADD;
                else                      w_next_state = S_SHL;
            end
            S_DONE: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_p     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m   <= i_op_a;
                        r_q   <= i_op_b;
                        r_p   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_p <= i_alu_result;
                    if (i_alu_carry_out) r_ovf <= 1'b1;
                end
                S_SHL: begin
                    r_m <= i_alu_result;
                    if (i_alu_carry_out && w_q_rest_nz) r_ovf <= 1'b1;
                end
                S_SHR: r_q <= i_alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: table of directed products, random products
// against an arithmetic model, backpressure and mid-operation reset.

module tb_alu_mul_sequencer;
    import definitions::*;

    localparam int W       = 8;
    localparam int MAX_LAT = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] product;
    logic         overflow;
    logic         alu_busy;
    logic [W-1:0] alu_src_a;
    logic [W-1:0] alu_src_b;
    logic [2:0]   alu_opcode;
    logic [1:0]   alu_funct;
    logic [W-1:0] alu_result;
    logic         alu_carry;
    logic [2:0]   dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];

    always #5 clk = ~clk;

    alu_mul_sequencer #(.D_WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start_valid(start_valid),
        .o_start_ready(start_ready),
        .i_op_a(op_a),
        .i_op_b(op_b),
        .o_resp_valid(resp_valid),
        .i_resp_ready(resp_ready),
        .o_product(product),
        .o_overflow(overflow),
        .o_alu_busy(alu_busy),
        .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b),
        .o_alu_opcode(alu_opcode),
        .o_alu_funct(alu_funct),
        .i_alu_result(alu_result),
        .i_alu_carry_out(alu_carry),
        .o_dbg_state(dbg_state)
    );

    // Shared ALU: add with carry, or a one-position shift with the lost bit as carry.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        if (alu_opcode == OP_R_TYPE && alu_funct == FUNCT_ADD) begin
            {alu_carry, alu_result} = {1'b0, alu_src_a} + {1'b0, alu_src_b};
        end else if (alu_opcode == OP_SHIFT && alu_funct == FUNCT_SLL) begin
            {alu_carry, alu_result} = {alu_src_a, 1'b0};
        end else if (alu_opcode == OP_SHIFT && alu_funct == FUNCT_SRL) begin
            alu_result = alu_src_a >> 1;
            alu_carry  = alu_src_a[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_latency(input logic [W-1:0] b);
        int n = 0;
        int k = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                n = i + 1;
                k++;
            end
        end
        return (b == '0) ? 1 : 1 + 2 * n + k;
    endfunction

    // One ADD per set multiplier bit, each bit position up to the MSB costs SLL+SRL.
    task automatic build_exp_ops(input logic [W-1:0] b);
        int n = 0;
        exp_q.delete();
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        for (int i = 0; i < n; i++) begin
            if (b[i]) exp_q.push_back({OP_R_TYPE, FUNCT_ADD});
            exp_q.push_back({OP_SHIFT, FUNCT_SLL});
            exp_q.push_back({OP_SHIFT, FUNCT_SRL});
        end
    endtask

    // Called #1 after a rising edge with the sequencer idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input int pulse_at, output int lat, output logic [W-1:0] prod,
                         output logic ovf, output int ovf_shl);
        int   shl_done = 0;
        logic mism = 1'b0;
        logic stable_bad = 1'b0;
        build_exp_ops(b);
        got_q.delete();
        ovf_shl = -1;
        check("idle_start_ready", {31'd0, start_ready}, 32'd1);
        op_a = a;
        op_b = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        lat = 1;
        while (!resp_valid && lat <= MAX_LAT) begin
            if (overflow && ovf_shl < 0) ovf_shl = shl_done;
            if (alu_busy) begin
                got_q.push_back({alu_opcode, alu_funct});
                if (alu_opcode == OP_SHIFT && alu_funct == FUNCT_SLL) shl_done++;
            end
            if (lat == pulse_at) begin
                start_valid = 1'b1;
                op_a = 8'h09;
                op_b = 8'h09;
                check("busy_start_ready", {31'd0, start_ready}, 32'd0);
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start_valid = 1'b0;
        check("resp_within_budget", {31'd0, resp_valid}, 32'd1);
        if (overflow && ovf_shl < 0) ovf_shl = shl_done;
        prod = product;
        ovf  = overflow;
        check("done_alu_defaults", {10'd0, alu_busy, alu_src_a, alu_src_b, alu_opcode, alu_funct},
              {10'd0, 1'b0, 8'd0, 8'd0, OP_R_TYPE, FUNCT_ADD});
        if (got_q.size() != exp_q.size()) mism = 1'b1;
        else for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) mism = 1'b1;
        check("alu_op_sequence", {31'd0, mism}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (!resp_valid || product !== prod || overflow !== ovf || start_ready) stable_bad = 1'b1;
        end
        if (hold > 0) check("backpressure_stable", {31'd0, stable_bad}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("idle_after_resp", {30'd0, start_ready, resp_valid}, 32'd2);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prod;
        logic         ovf;
        int           lat;
        int           ovf_shl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int           lat;
        int           oshl;
        logic [W-1:0] p;
        logic         o;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           full;

        vecs[0] = '{8'h05, 8'h03, 8'h0F, 1'b0,  7, -1};
        vecs[1] = '{8'h37, 8'h00, 8'h00, 1'b0,  1, -1};
        vecs[2] = '{8'h10, 8'h10, 8'h00, 1'b1, 12,  4};
        vecs[3] = '{8'hFF, 8'h01, 8'hFF, 1'b0,  4, -1};
        vecs[4] = '{8'hFF, 8'h02, 8'hFE, 1'b1,  6,  1};
        vecs[5] = '{8'h00, 8'hFF, 8'h00, 1'b0, 25, -1};
        vecs[6] = '{8'hFF, 8'hFF, 8'h01, 1'b1, 25,  1};
        vecs[7] = '{8'h02, 8'h03, 8'h06, 1'b0,  7, -1};
        vecs[8] = '{8'h0F, 8'h11, 8'hFF, 1'b0, 13, -1};
        vecs[9] = '{8'h80, 8'h02, 8'h00, 1'b1,  6,  1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {20'd0, start_ready, resp_valid, product, overflow, alu_busy},
              {20'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
        check("reset_state_idle", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, -1, lat, p, o, oshl);
            check($sformatf("vec%0d_product", i), {24'd0, p}, {24'd0, vecs[i].prod});
            check($sformatf("vec%0d_overflow", i), {31'd0, o}, {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ovf_shl", i), oshl, vecs[i].ovf_shl);
        end

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            case (i % 4)
                0: rb = W'($urandom_range(0, 255));
                1: rb = W'(1 << $urandom_range(0, W - 1));
                2: rb = W'($urandom_range(0, 15));
                default: rb = W'($urandom_range(128, 255));
            endcase
            full = int'(ra) * int'(rb);
            do_op(ra, rb, 0, -1, lat, p, o, oshl);
            check($sformatf("rand%0d_product", i), {24'd0, p}, full & 32'hFF);
            check($sformatf("rand%0d_overflow", i), {31'd0, o}, (full > 255) ? 32'd1 : 32'd0);
            check($sformatf("rand%0d_latency", i), lat, model_latency(rb));
        end

        do_op(8'h03, 8'h03, 5, 2, lat, p, o, oshl);
        check("bp_product", {24'd0, p}, 32'h09);
        check("bp_overflow", {31'd0, o}, 32'd0);
        @(posedge clk);
        #1;
        check("bp_no_late_accept", {31'd0, start_ready}, 32'd1);

        op_a = 8'hFF;
        op_b = 8'hFF;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("midop_busy", {31'd0, alu_busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midop_reset_outputs", {20'd0, start_ready, resp_valid, product, overflow, alu_busy},
              {20'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midop_no_response", {31'd0, resp_valid}, 32'd0);
        do_op(8'h02, 8'h03, 0, -1, lat, p, o, oshl);
        check("post_reset_product", {24'd0, p}, 32'h06);
        check("post_reset_overflow", {31'd0, o}, 32'd0);
        check("post_reset_latency", lat, 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
